// File: rtl/gb_interrupt_ctrl.sv
// Game Boy interrupt controller: owns IF (0xFF0F) and IE (0xFFFF), edge-detects the
// five request lines into IF and returns the highest-priority vector on CPU acknowledge.
module gb_interrupt_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_i,
   input  logic [15:0] addr,
   input  logic        wren,
   output logic [7:0]  data_o,
   input  logic        irq_vblank,
   input  logic        irq_stat,
   input  logic        irq_timer,
   input  logic        irq_serial,
   input  logic        irq_joypad,
   input  logic        int_ack,
   output logic        int_pending,
   output logic [7:0]  int_vector
);

   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   logic [4:0] if_q;
   logic [7:0] ie_q;
   logic [4:0] req_prev;
   logic [4:0] req;
   logic [4:0] set;
   logic [4:0] pend;
   logic [4:0] clr;
   logic [4:0] base;
   logic [4:0] if_next;
   logic [7:0] vec;
   logic       wr_if;
   logic       wr_ie;

   assign req   = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
   assign set   = req & ~req_prev;
   assign pend  = ie_q[4:0] & if_q;
   assign wr_if = wren && (addr == ADDR_IF);
   assign wr_ie = wren && (addr == ADDR_IE);

   assign int_pending = |pend;

   // Lowest pending index wins; vec/clr stay zero when nothing enabled is pending.
   always_comb begin
      vec = 8'h00;
      clr = 5'b00000;
      if (pend[0]) begin
         vec = 8'h40;
         clr = 5'b00001;
      end else if (pend[1]) begin
         vec = 8'h48;
         clr = 5'b00010;
      end else if (pend[2]) begin
         vec = 8'h50;
         clr = 5'b00100;
      end else if (pend[3]) begin
         vec = 8'h58;
         clr = 5'b01000;
      end else if (pend[4]) begin
         vec = 8'h60;
         clr = 5'b10000;
      end
   end

   // int_ack is a one-cycle strobe with no back-pressure: each sampled ack consumes
   // at most one IF bit, and a fresh request edge always wins over clear or write.
   always_comb begin
      base    = wr_if ? data_i[4:0] : if_q;
      if_next = (base & ~(int_ack ? clr : 5'b00000)) | set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_q       <= 5'b00000;
         ie_q       <= 8'h00;
         req_prev   <= 5'b00000;
         int_vector <= 8'h00;
      end else begin
         if_q     <= if_next;
         req_prev <= req;
         if (wr_ie)
            ie_q <= data_i;
         if (int_ack)
            int_vector <= vec;
      end
   end

   always_comb begin
      data_o = 8'h00;
      if (addr == ADDR_IF)
         data_o = {3'b111, if_q};
      else if (addr == ADDR_IE)
         data_o = ie_q;
   end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Bench for gb_interrupt_ctrl: directed steps followed by random traffic, all checked
// against a bit-list reference model of the IF/IE/vector behaviour.
module tb_gb_interrupt_ctrl;

   logic        clk;
   logic        reset;
   logic [7:0]  data_i;
   logic [15:0] addr;
   logic        wren;
   logic [7:0]  data_o;
   logic [4:0]  irq;
   logic        int_ack;
   logic        int_pending;
   logic [7:0]  int_vector;

   int n_vec;
   int n_err;

   // reference model state
   bit m_if   [5];
   bit m_ie   [8];
   bit m_prev [5];
   int m_vec;

   gb_interrupt_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .data_i      (data_i),
      .addr        (addr),
      .wren        (wren),
      .data_o      (data_o),
      .irq_vblank  (irq[0]),
      .irq_stat    (irq[1]),
      .irq_timer   (irq[2]),
      .irq_serial  (irq[3]),
      .irq_joypad  (irq[4]),
      .int_ack     (int_ack),
      .int_pending (int_pending),
      .int_vector  (int_vector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_if_read();
      int v;
      v = 224;
      for (int i = 0; i < 5; i++) v += m_if[i] * (1 << i);
      return v[7:0];
   endfunction

   function automatic logic [7:0] m_ie_read();
      int v;
      v = 0;
      for (int i = 0; i < 8; i++) v += m_ie[i] * (1 << i);
      return v[7:0];
   endfunction

   function automatic logic m_pending();
      for (int i = 0; i < 5; i++) if (m_ie[i] && m_if[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin m_if[i] = 0; m_prev[i] = 0; end
      for (int i = 0; i < 8; i++) m_ie[i] = 0;
      m_vec = 0;
   endtask

   // One clock edge of the interrupt rules, using the inputs driven for that edge.
   task automatic model_edge();
      int  sel;
      bit  nif [5];
      sel = -1;
      for (int i = 4; i >= 0; i--) if (m_ie[i] && m_if[i]) sel = i;
      for (int i = 0; i < 5; i++) nif[i] = m_if[i];
      if (wren && addr == 16'hFF0F)
         for (int i = 0; i < 5; i++) nif[i] = data_i[i];
      if (int_ack) begin
         m_vec = (sel >= 0) ? 64 + 8 * sel : 0;
         if (sel >= 0) nif[sel] = 0;
      end
      for (int i = 0; i < 5; i++) if (irq[i] && !m_prev[i]) nif[i] = 1;
      for (int i = 0; i < 5; i++) begin m_if[i] = nif[i]; m_prev[i] = irq[i]; end
      if (wren && addr == 16'hFFFF)
         for (int i = 0; i < 8; i++) m_ie[i] = data_i[i];
   endtask

   // Compare every observable against the model; reads are combinational so the bus
   // is swept between edges.
   task automatic check_all(input string tag);
      wren    = 1'b0;
      int_ack = 1'b0;
      addr    = 16'hFF0F;
      #1 chk({tag, "_if"}, data_o, m_if_read());
      addr = 16'hFFFF;
      #1 chk({tag, "_ie"}, data_o, m_ie_read());
      addr = 16'hC000;
      #1 chk({tag, "_other"}, data_o, 8'h00);
      chk({tag, "_pend"}, {7'd0, int_pending}, {7'd0, m_pending()});
      chk({tag, "_vec"}, int_vector, m_vec[7:0]);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr   = a;
      data_i = d;
      wren   = 1'b1;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b0;
      data_i  = 8'h00;
      addr    = 16'h0000;
      wren    = 1'b0;
      irq     = 5'b00000;
      int_ack = 1'b0;
      model_reset();

      // reset values
      #12;
      check_all("rst");
      chk("rst_if_const", m_if_read(), 8'hE0);
      @(negedge clk);
      reset = 1'b1;

      // edge detect on a long-held timer request
      wr(16'hFFFF, 8'h04);
      tick("t2_ie");
      irq[2] = 1'b1;
      tick("t2_set");
      addr = 16'hFF0F;
      #1 chk("t2_if_e4", data_o, 8'hE4);
      for (int i = 0; i < 8; i++) tick("t2_hold");
      int_ack = 1'b1;
      tick("t2_ack");
      chk("t2_vec_50", int_vector, 8'h50);
      tick("t2_noreset");
      tick("t2_noreset");
      irq[2] = 1'b0;
      tick("t2_fall");

      // priority chain, back-to-back acks
      wr(16'hFFFF, 8'h1F);
      tick("t3_ie");
      wr(16'hFF0F, 8'h1A);
      tick("t3_if");
      int_ack = 1'b1;
      tick("t3_ack0");
      chk("t3_vec_48", int_vector, 8'h48);
      int_ack = 1'b1;
      tick("t3_ack1");
      chk("t3_vec_58", int_vector, 8'h58);
      int_ack = 1'b1;
      tick("t3_ack2");
      chk("t3_vec_60", int_vector, 8'h60);

      // masking and cancelled dispatch
      wr(16'hFFFF, 8'h00);
      tick("t4_ie0");
      irq[4] = 1'b1;
      tick("t4_joy");
      wr(16'hFFFF, 8'h10);
      tick("t4_ie10");
      wr(16'hFFFF, 8'h00);
      tick("t4_ieclr");
      int_ack = 1'b1;
      tick("t4_cancel");
      chk("t4_vec_00", int_vector, 8'h00);
      irq[4] = 1'b0;
      tick("t4_fall");

      // collisions: ack vs new edge, write 0 vs new edge
      wr(16'hFF0F, 8'h04);
      tick("t5_if");
      wr(16'hFFFF, 8'h04);
      tick("t5_ie");
      int_ack = 1'b1;
      irq[2]  = 1'b1;
      tick("t5_ack_edge");
      addr = 16'hFF0F;
      #1 chk("t5_if_e4", data_o, 8'hE4);
      irq[2] = 1'b0;
      tick("t5_fall");
      wr(16'hFF0F, 8'h00);
      irq[0] = 1'b1;
      tick("t5_wr_edge");
      addr = 16'hFF0F;
      #1 chk("t5_if_e1", data_o, 8'hE1);
      irq[0] = 1'b0;
      tick("t5_vfall");

      // asynchronous reset between edges, released with a request held high
      wr(16'hFF0F, 8'h1F);
      tick("t6_if");
      wr(16'hFFFF, 8'hFF);
      tick("t6_ie");
      #1 reset = 1'b0;
      irq[1] = 1'b1;
      #1 model_reset();
      check_all("t6_async");
      @(negedge clk);
      reset = 1'b1;
      tick("t6_release");
      addr = 16'hFF0F;
      #1 chk("t6_if_e2", data_o, 8'hE2);
      irq[1] = 1'b0;
      tick("t6_fall");

      // random traffic
      for (int n = 0; n < 300; n++) begin
         int r;
         irq     = 5'($urandom_range(0, 31));
         int_ack = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 5);
         if (r == 0)      wr(16'hFF0F, 8'($urandom));
         else if (r == 1) wr(16'hFFFF, 8'($urandom));
         else if (r == 2) wr(16'($urandom), 8'($urandom));
         tick("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gb_interrupt_ctrl.md
# gb_interrupt_ctrl

Interrupt controller that sits directly downstream of `gb_timer` and the other interrupt sources (PPU, serial, joypad). It owns the IF (0xFF0F) and IE (0xFFFF) registers, edge-detects the five request lines into IF, and reports to the CPU core whether an enabled interrupt is pending. On CPU acknowledge it hands back the highest-priority vector and clears that IF bit.

## Interface
Parameters: none.

- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `data_i` in 8: CPU write data.
- `addr` in 16: CPU bus address.
- `wren` in 1: CPU write strobe, sampled at `clk` rising edge.
- `data_o` out 8: combinational read data for 0xFF0F/0xFFFF; 0x00 for any other address.
- `irq_vblank` in 1: request, bit 0, highest priority.
- `irq_stat` in 1: request, bit 1.
- `irq_timer` in 1: request, bit 2 (from `gb_timer`).
- `irq_serial` in 1: request, bit 3.
- `irq_joypad` in 1: request, bit 4, lowest priority.
- `int_ack` in 1: one-cycle CPU dispatch acknowledge.
- `int_pending` out 1: `|(IE[4:0] & IF[4:0])`, combinational from registers. Also used as the HALT wake signal, independent of IME (IME is owned by the CPU).
- `int_vector` out 8: registered vector latched on ack.

## Operation
- **State**
  - `IF[4:0]`, `IE[7:0]`, `req_prev[4:0]`, `int_vector[7:0]`.
  - All reset to 0x00 when `reset` is low, asynchronously.
- **Edge detect**
  - `set[i] = irq_i & ~req_prev[i]`.
  - `req_prev` is loaded with the current requests every cycle.
  - A request held high for many cycles sets IF exactly once. It must fall and rise again to re-request.
- **Priority**
  - `sel` is the lowest index `i` with `IE[i] & IF[i]`, evaluated on the pre-edge register values.
  - Vector is `0x40 + 8*sel`: 0x40, 0x48, 0x50, 0x58, 0x60.
- **Acknowledge** (`int_ack` high at an edge)
  - If any enabled bit is pending: `int_vector <= vector(sel)` and `clr = 1<<sel`.
  - If none is pending: `int_vector <= 0x00` and `clr = 0` (cancelled-dispatch case).
  - `int_vector` holds its value until the next ack.
- **IF next-state**, in priority order:
  - `base = (wren && addr==0xFF0F) ? data_i[4:0] : IF`.
  - `IF_next = (base & ~clr) | set`.
  - Consequences: a new request edge beats both the ack-clear and a CPU write of 0. The ack-clear also applies to same-cycle write data.
- **IE**
  - `wren && addr==0xFFFF` loads all 8 bits.
  - Only bits [4:0] participate in pending and priority.
- **Reads**
  - 0xFF0F returns `{3'b111, IF}`.
  - 0xFFFF returns `IE`.
  - Any other address returns 0x00.
- **Unused addresses:** writes elsewhere are ignored.

## Timing
- **Request to pending:** a request edge present before rising edge N makes IF set after edge N. `int_pending` and the IF readback reflect it in cycle N+1 (1-cycle latency).
- **Register writes:** a write at edge N is visible on `data_o` and `int_pending` from edge N onward.
- **Ack:** ack at edge N updates `int_vector` and clears the IF bit at edge N. `int_pending` drops after N if no other enabled bit remains.
- **Back-to-back acks:** consecutive-cycle acks each consume one bit, in priority order.
- **Reset mid-operation:** IF, IE, `req_prev` and `int_vector` clear immediately. A request line that is high when reset releases counts as a rising edge on the first clock (`req_prev` = 0).
- **Reset values:** `data_o` reads 0xE0 at 0xFF0F and 0x00 at 0xFFFF; `int_pending` = 0; `int_vector` = 0x00.

## Test plan
1. **Reset:** pulse `reset` low, read both registers -> 0xFF0F = 0xE0, 0xFFFF = 0x00, `int_pending` = 0, `int_vector` = 0x00.
2. **Edge detect:** write IE = 0x04, hold `irq_timer` high for 10 cycles -> IF = 0xE4 after the first edge, `int_pending` = 1 from the next cycle. Ack -> `int_vector` = 0x50, IF = 0xE0, pending = 0, with no re-set while the line stays high.
3. **Priority chain:** IE = 0x1F, write IF = 0x1A, ack on 3 consecutive cycles -> vectors 0x48, 0x58, 0x60 in order. IF = 0xE0 afterwards.
4. **Masking:** IE = 0x00, raise `irq_joypad` -> IF = 0xF0, `int_pending` = 0. Write IE = 0x10 -> pending = 1. Ack with IE cleared first -> `int_vector` = 0x00, IF unchanged at 0xF0.
5. **Collisions:** in one cycle, ack with IF = 0x04/IE = 0x04 plus a new `irq_timer` rising edge -> `int_vector` = 0x50, IF stays 0xE4. Separately, write IF = 0x00 in the same cycle as an `irq_vblank` edge -> IF = 0xE1.
6. **Async reset mid-operation:** with IF = 0x1F, IE = 0xFF, assert `reset` between clock edges -> all state clears without waiting for `clk`. Release it with `irq_stat` held high -> IF = 0xE2 after the first edge.
